// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table controller.
//   - default geometry (index width, counter width)
//   - controller state encoding
//   - init value helper: weakly not-taken for an N-bit counter
package bht_pkg;

  localparam int BHT_IDX_W = 32'sd4;
  localparam int BHT_N     = 32'sd2;

  typedef enum logic [0:0] {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_e;

  // Largest counter value that still predicts not-taken: 2**(n-1)-1.
  function automatic int bht_init_val(input int n);
    return (32'sd1 << (n - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/bht_sat_next.sv
// Saturating up/down step for one N-bit branch counter.
// Ports:
//   cur   - current counter value
//   taken - resolved outcome (1: count up, 0: count down)
//   nxt   - next counter value, clamped to [0, 2**N-1]
module bht_sat_next #(
  parameter int N = 32'sd2
) (
  input  logic [N-1:0] cur,
  input  logic         taken,
  output logic [N-1:0] nxt
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_MIN = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE = N'(1'b1);

  // Step towards the outcome, holding at either rail.
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur == CNT_MAX) begin
        nxt = cur;
      end else begin
        nxt = cur + CNT_ONE;
      end
    end else begin
      if (cur == CNT_MIN) begin
        nxt = cur;
      end else begin
        nxt = cur - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller.
// Owns 2**IDX_W saturating N-bit counters. Walks the table writing INIT_VAL
// after reset and on flush, then serves one lookup and one update per cycle.
// Ports:
//   clk, reset          - rising-edge clock, async active-low reset
//   flush               - restart the init walk
//   lookup_valid/_idx   - prediction request (fetch side)
//   pred_valid/_taken   - registered prediction, one cycle after lookup
//   upd_valid/_idx/_taken - resolved branch training (execute side)
//   upd_ready           - update accepted this cycle (not busy)
//   busy                - init walk in progress
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W    = BHT_IDX_W,
  parameter int N        = BHT_N,
  parameter int INIT_VAL = bht_init_val(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);

  localparam int             DEPTH    = 32'sd1 << IDX_W;
  localparam logic [0:0]     ST_INIT  = BHT_INIT;
  localparam logic [0:0]     ST_RUN   = BHT_RUN;
  localparam logic [N-1:0]   INIT_CNT = N'(INIT_VAL);
  localparam logic [IDX_W:0] PTR_ONE  = (IDX_W + 1)'(1'b1);
  localparam logic [IDX_W:0] PTR_ZERO = {(IDX_W + 1){1'b0}};

  logic [0:0]     state_r;
  logic [0:0]     state_nxt_s;
  logic [IDX_W:0] walk_ptr_r;
  logic [IDX_W:0] walk_ptr_inc_s;
  logic           walk_done_s;
  logic [N-1:0]   table_r [DEPTH];
  logic           upd_en_s;
  logic           lkp_en_s;
  logic           bypass_s;
  logic [N-1:0]   upd_cur_s;
  logic [N-1:0]   upd_nxt_s;
  logic [N-1:0]   lkp_val_s;
  logic           pred_valid_r;
  logic           pred_taken_r;
  logic           busy_r;

  // The extra pointer bit flags that the last entry is being written now.
  assign walk_ptr_inc_s = walk_ptr_r + PTR_ONE;
  assign walk_done_s    = walk_ptr_inc_s[IDX_W];

  // Update/lookup qualification and same-entry bypass of the fresh value.
  always_comb begin
    upd_en_s  = (state_r == ST_RUN) && upd_valid && !flush;
    lkp_en_s  = (state_r == ST_RUN) && lookup_valid && !flush;
    bypass_s  = upd_en_s && lkp_en_s && (upd_idx == lookup_idx);
    upd_cur_s = table_r[upd_idx];
    if (bypass_s) begin
      lkp_val_s = upd_nxt_s;
    end else begin
      lkp_val_s = table_r[lookup_idx];
    end
  end

  bht_sat_next #(
    .N (N)
  ) u_sat_next (
    .cur   (upd_cur_s),
    .taken (upd_taken),
    .nxt   (upd_nxt_s)
  );

  // Next-state: flush always forces a fresh walk.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (flush) begin
          state_nxt_s = ST_INIT;
        end else if (walk_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Control registers: state, walk pointer, busy and prediction outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_INIT;
      walk_ptr_r   <= PTR_ZERO;
      busy_r       <= 1'b1;
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_INIT);
      if ((state_r == ST_INIT) && !flush && !walk_done_s) begin
        walk_ptr_r <= walk_ptr_inc_s;
      end else begin
        walk_ptr_r <= PTR_ZERO;
      end
      pred_valid_r <= lkp_en_s;
      pred_taken_r <= lkp_en_s && lkp_val_s[N-1];
    end
  end

  // Counter storage: init walk writes, otherwise training writes.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      table_r[walk_ptr_r[IDX_W-1:0]] <= INIT_CNT;
    end else if (upd_en_s) begin
      table_r[upd_idx] <= upd_nxt_s;
    end
  end

  assign pred_valid = pred_valid_r;
  assign pred_taken = pred_taken_r;
  assign busy       = busy_r;
  assign upd_ready  = !busy_r;

endmodule

// File: doc/bht_ctrl.md
Name: bht_ctrl

Overview:
- Branch history table controller: owns 2**IDX_W saturating N-bit counters, serves one prediction lookup and one training update per cycle.
- Sequences table initialisation after reset and on flush; sits between fetch (lookup) and execute (resolved-branch update).
- Prediction is the counter MSB (taken when counter >= 2**(N-1)).

Parameters:
- IDX_W, 4, table index width; table depth = 2**IDX_W.
- N, 2, counter width in bits.
- INIT_VAL, 2**(N-1)-1, value written to every entry during init (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  request full table re-initialisation.
- lookup_valid  in  1  lookup request this cycle.
- lookup_idx  in  IDX_W  entry to predict.
- pred_valid  out  1  registered; prediction available.
- pred_taken  out  1  registered; predicted direction.
- upd_valid  in  1  resolved branch update this cycle.
- upd_idx  in  IDX_W  entry to train.
- upd_taken  in  1  actual branch outcome.
- upd_ready  out  1  update accepted this cycle (== !busy).
- busy  out  1  init walk in progress.

Behaviour:
- Reset (reset==0, asynchronous): state=INIT, walk_ptr=0, pred_valid=0, pred_taken=0, busy=1, upd_ready=0. Table contents undefined until the walk writes them.
- States: INIT, RUN.
- INIT:
  - Each cycle write INIT_VAL to table[walk_ptr], then walk_ptr++.
  - After writing entry 2**IDX_W-1, go to RUN. busy is 0 from the following cycle.
  - Init takes exactly 2**IDX_W cycles after reset release.
  - Lookups and updates are ignored: pred_valid=0 next cycle, table untouched.
  - flush during INIT restarts the walk: walk_ptr=0.
- RUN:
  - flush=1: go to INIT with walk_ptr=0 on the next edge. Any same-cycle update and lookup are dropped (pred_valid=0).
- Update, in RUN with upd_valid=1, applied at the clock edge (single-cycle read-modify-write):
  - taken: counter+1, saturating at 2**N-1.
  - not taken: counter-1, saturating at 0.
  - No wrap-around under any sequence.
- Lookup, latency 1:
  - pred_valid <= lookup_valid && state==RUN && !flush.
  - pred_taken <= MSB of table[lookup_idx].
  - When pred_valid<=0, pred_taken <= 0.
- Same-cycle bypass: if upd_valid && lookup_valid && upd_idx==lookup_idx, pred_taken uses the post-update value.
- Updates to different indices never disturb other entries.
- Reset asserted mid-walk or mid-run: immediate return to reset values; the walk restarts from 0 after release.

Decomposition:
- Package bht_pkg:
  - state enum {INIT, RUN}.
  - Default IDX_W/N constants.
  - INIT_VAL function of N.
- Sub-module bht_sat_next: combinational (cur, taken) -> next saturating value. Instantiated once for the update path; its output also feeds the bypass.
- Table held in flops; walk_ptr is a separate counter of width IDX_W+1 so the terminal count is detectable.

Test Plan:
- Release reset -> busy=1 for 16 cycles, upd_ready=0; lookup idx 3 issued during busy -> pred_valid=0 next cycle; after busy falls, lookup idx 3 -> pred_valid=1, pred_taken=0.
- Two taken updates to idx 5 (1->2->3), then lookup idx 5 -> pred_taken=1; lookup idx 6 -> pred_taken=0.
- Saturation up: five taken updates to idx 2 (counter held at 3), then one not-taken (counter 2) -> lookup pred_taken=1. Saturation down: three not-taken to idx 9, then one taken (counter 1) -> pred_taken=0.
- Bypass: idx 7 at counter 1; same cycle upd_valid=1, upd_taken=1, lookup idx 7 -> next cycle pred_taken=1, and table[7]=2.
- flush in RUN after training idx 5 to 3 -> busy=1 for 16 cycles, same-cycle lookup gives pred_valid=0; afterwards lookup idx 5 -> pred_taken=0.
- Reset pulsed low at walk cycle 8 -> outputs immediately return to reset values; after release, busy stays high a full 16 cycles.
